// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, flush, bubble insertion and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready; the default build is single-entry.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        o_dbg_state   // 0 EMPTY, 1 ONE, 2 FULL (number of held entries)
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Upstream may not rely on in_ready being independent of in_valid; downstream sees out_* stable while stalled.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_out_valid;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_in_xfer   = in_valid & in_ready;
  assign w_out_xfer  = r_out_valid & out_ready;
  assign out_valid   = r_out_valid;
  assign out_ctrl    = r_out_ctrl;
  assign out_data    = r_out_data;
  assign stall_cnt   = r_stall_cnt;
  assign o_dbg_state = r_state;

  // Counts every back-pressured edge, flush or not; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;

  // Only clr gates the registered ready; out_ready never reaches in_ready combinationally.
  assign in_ready = r_in_ready & ~clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_out_ctrl  <= in_ctrl;
            r_out_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_out_ctrl <= in_ctrl;
            r_out_data <= in_data;
          end else if (w_in_xfer) begin
            r_state     <= ST_FULL;
            r_in_ready  <= 1'b0;
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
          end else if (w_out_xfer) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
            r_out_ctrl <= r_skid_ctrl;
            r_out_data <= r_skid_data;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_ctrl  <= '0;
        end
      endcase
    end
  end
`else
  assign in_ready = ~clr & (~r_out_valid | out_ready);

  // A new instruction wins over the bubble when both transfers land on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
    end else if (w_in_xfer) begin
      r_state     <= ST_ONE;
      r_out_valid <= 1'b1;
      r_out_ctrl  <= in_ctrl;
      r_out_data  <= in_data;
    end else if (w_out_xfer) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
    end
  end
`endif

endmodule
